// File: rtl/gate_tick_gen_pkg.sv
// Shared types and default sizing for the frequency-counter gate/tick timer.
package gate_tick_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_TCNT_W = 8;
    localparam int unsigned DEF_TERM   = 999;

endpackage

// File: rtl/gate_tick_gen_if.sv
// Control/status bundle between the gate/tick timer and its controller.
interface gate_tick_gen_if
    import gate_tick_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned TCNT_W = DEF_TCNT_W
);
    logic              en;
    logic              mode;
    logic              start;
    logic [CNT_W-1:0]  term_in;
    logic              term_vld;
    logic              cnt_clr;
    logic              tick;
    logic              gate;
    logic              busy;
    logic [CNT_W-1:0]  cur_cnt;
    logic [TCNT_W-1:0] tick_cnt;

    modport master (
        output en, mode, start, term_in, term_vld, cnt_clr,
        input  tick, gate, busy, cur_cnt, tick_cnt
    );

    modport slave (
        input  en, mode, start, term_in, term_vld, cnt_clr,
        output tick, gate, busy, cur_cnt, tick_cnt
    );
endinterface

// File: rtl/gate_tick_gen.sv
// Programmable sample/gate timer: periodic tick (continuous) or single gate window (one-shot).
// New periods are staged in a shadow register and only take effect at a period boundary.
module gate_tick_gen
    import gate_tick_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned DEFAULT_TERM = DEF_TERM,
    parameter int unsigned TCNT_W       = DEF_TCNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    gate_tick_gen_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   active_q, active_d;
    logic [CNT_W-1:0]   shadow_q, shadow_d;
    logic               mode_q, mode_d;
    logic               tick_q, tick_d;
    logic               gate_q, gate_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        tcnt_d   = tcnt_q;
        // A same-cycle term_vld is visible to a boundary load happening on this edge
        shadow_d = bus.term_vld ? bus.term_in : shadow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.en && (bus.mode == MODE_CONT || bus.start)) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    mode_d   = bus.mode;
                    active_d = shadow_d;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == active_q) begin
                    tick_d = 1'b1;
                    cnt_d  = '0;
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (mode_q == MODE_ONESHOT) begin
                        state_d = IDLE;
                    end else begin
                        active_d = shadow_d;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.cnt_clr) begin
            tcnt_d = '0;
        end
        gate_d = (state_d == RUN);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= CNT_W'(DEFAULT_TERM);
            shadow_q <= CNT_W'(DEFAULT_TERM);
            mode_q   <= MODE_CONT;
            tick_q   <= 1'b0;
            gate_q   <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            gate_q   <= gate_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.gate     = gate_q;
    assign bus.busy     = gate_q;
    assign bus.cur_cnt  = cnt_q;
    assign bus.tick_cnt = tcnt_q;

endmodule
